layer_out_serializer: RTL

- Sits between two fully connected layers. Consumes the parallel `out`/`outvalid` results of every neuron in layer N and replays them as a serial `myinput`/`myinputValid` stream into every neuron of layer N+1.
- Neuron 0 is sent first.
- Double-buffered, so a new layer result can arrive while the previous one is still streaming.
- Flags partial or overrun captures.

---
 rtl/layer_out_serializer_pkg.sv | 21 ++
 rtl/layer_out_serializer_ser_buf.sv | 58 +++++
 rtl/layer_out_serializer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/layer_out_serializer_pkg.sv
// Shared types and helpers for the layer-output serializer.
package fnn_ser_pkg;

   // Serializer control states: waiting for a layer result, or streaming one.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // Width of a neuron index; never narrower than one bit.
   function automatic int idx_width(input int n);
      int w;
      if (n > 1) begin
         w = $clog2(n);
      end else begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/layer_out_serializer_ser_buf.sv
// Register bank of numNeuron words with a parallel load, an indexed read
// port and a full parallel view (used to copy one bank into another).
module ser_buf
   import fnn_ser_pkg::*;
#(
   parameter int numNeuron = 30,
   parameter int dataWidth = 16,
   localparam int IW = idx_width(numNeuron)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           load,
   input  logic [numNeuron*dataWidth-1:0] din,
   input  logic [IW-1:0]                  rd_idx,
   output logic [dataWidth-1:0]           rd_data,
   output logic [numNeuron*dataWidth-1:0] dout
);

   logic [dataWidth-1:0] mem_q [numNeuron];
   logic [dataWidth-1:0] mem_d [numNeuron];

   // Next bank contents: take the whole input vector on load, else hold.
   always_comb begin
      for (int i = 0; i < numNeuron; i++) begin
         if (load) begin
            mem_d[i] = din[i*dataWidth +: dataWidth];
         end else begin
            mem_d[i] = mem_q[i];
         end
      end
   end

   // Bank storage, cleared by reset so stale layer data never leaks out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < numNeuron; i++) begin
            mem_q[i] <= {dataWidth{1'b0}};
         end
      end else begin
         for (int i = 0; i < numNeuron; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Indexed read of one stored word.
   always_comb begin
      rd_data = mem_q[rd_idx];
   end

   // Flatten the bank back into the packed neuron layout.
   always_comb begin
      for (int i = 0; i < numNeuron; i++) begin
         dout[i*dataWidth +: dataWidth] = mem_q[i];
      end
   end

endmodule

// File: rtl/layer_out_serializer.sv
// Replays the parallel outputs of one fully connected layer as a gap-free
// serial stream (neuron 0 first) into the next layer. A holding bank lets a
// new layer result arrive while the previous one is still streaming.
module layer_out_serializer
   import fnn_ser_pkg::*;
#(
   parameter int numNeuron = 30,
   parameter int dataWidth = 16,
   localparam int IW = idx_width(numNeuron)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [numNeuron*dataWidth-1:0] neuron_out,
   input  logic [numNeuron-1:0]           neuron_valid,
   output logic [dataWidth-1:0]           ser_data,
   output logic                           ser_valid,
   output logic [IW-1:0]                  ser_idx,
   output logic                           busy,
   output logic                           err_partial,
   output logic                           err_overrun,
   input  logic                           err_clr
);

   localparam logic [IW-1:0] LAST_IDX = IW'(numNeuron - 1);
   localparam logic [IW-1:0] ZERO_IDX = {IW{1'b0}};

   ser_state_t                     state_q, state_d;
   logic [IW-1:0]                  idx_q, idx_d;
   logic [dataWidth-1:0]           data_q, data_d;
   logic                           valid_q, valid_d;
   logic                           busy_q, busy_d;
   logic                           pend_q, pend_d;
   logic                           perr_q, perr_d;
   logic                           oerr_q, oerr_d;

   logic                           cap_s;
   logic                           partial_s;
   logic                           overrun_s;
   logic                           shift_load_s;
   logic                           hold_load_s;
   logic [numNeuron*dataWidth-1:0] shift_din_s;
   logic [numNeuron*dataWidth-1:0] hold_all_s;
   logic [numNeuron*dataWidth-1:0] shift_all_unused_s;
   logic [dataWidth-1:0]           shift_rd_s;
   logic [dataWidth-1:0]           hold_rd_s;
   logic [IW-1:0]                  next_idx_s;

   // Shift bank: the layer currently being streamed; read one beat ahead.
   ser_buf #(.numNeuron(numNeuron), .dataWidth(dataWidth)) u_shift (
      .clk     (clk),
      .rst     (rst),
      .load    (shift_load_s),
      .din     (shift_din_s),
      .rd_idx  (next_idx_s),
      .rd_data (shift_rd_s),
      .dout    (shift_all_unused_s)
   );

   // Holding bank: one layer parked while the shift bank is busy.
   ser_buf #(.numNeuron(numNeuron), .dataWidth(dataWidth)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load    (hold_load_s),
      .din     (neuron_out),
      .rd_idx  (ZERO_IDX),
      .rd_data (hold_rd_s),
      .dout    (hold_all_s)
   );

   // Capture qualification: a layer counts only when every neuron is valid.
   always_comb begin
      cap_s      = &neuron_valid;
      partial_s  = (|neuron_valid) & ~cap_s;
      next_idx_s = idx_q + IW'(1);
   end

   // Stream control: next state, beat index, outgoing word and bank loads.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      data_d       = data_q;
      valid_d      = valid_q;
      busy_d       = busy_q;
      pend_d       = pend_q;
      shift_load_s = 1'b0;
      shift_din_s  = neuron_out;
      hold_load_s  = 1'b0;
      overrun_s    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cap_s) begin
               shift_load_s = 1'b1;
               idx_d        = ZERO_IDX;
               data_d       = neuron_out[dataWidth-1:0];
               valid_d      = 1'b1;
               busy_d       = 1'b1;
               state_d      = SHIFT;
            end else begin
               idx_d        = ZERO_IDX;
               data_d       = {dataWidth{1'b0}};
               valid_d      = 1'b0;
               busy_d       = 1'b0;
            end
         end
         SHIFT: begin
            if (idx_q == LAST_IDX) begin
               // Last beat: a fresh capture beats the parked layer, which waits its turn.
               if (cap_s) begin
                  shift_load_s = 1'b1;
                  shift_din_s  = neuron_out;
                  idx_d        = ZERO_IDX;
                  data_d       = neuron_out[dataWidth-1:0];
               end else if (pend_q) begin
                  shift_load_s = 1'b1;
                  shift_din_s  = hold_all_s;
                  pend_d       = 1'b0;
                  idx_d        = ZERO_IDX;
                  data_d       = hold_rd_s;
               end else begin
                  state_d      = IDLE;
                  idx_d        = ZERO_IDX;
                  data_d       = {dataWidth{1'b0}};
                  valid_d      = 1'b0;
                  busy_d       = 1'b0;
               end
            end else begin
               idx_d  = next_idx_s;
               data_d = shift_rd_s;
               if (cap_s) begin
                  if (pend_q) begin
                     overrun_s   = 1'b1;
                  end else begin
                     hold_load_s = 1'b1;
                     pend_d      = 1'b1;
                  end
               end else begin
                  pend_d = pend_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = ZERO_IDX;
            data_d  = {dataWidth{1'b0}};
            valid_d = 1'b0;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
         end
      endcase
   end

   // Sticky error flags: a same-cycle set wins over a clear.
   always_comb begin
      if (partial_s) begin
         perr_d = 1'b1;
      end else if (err_clr) begin
         perr_d = 1'b0;
      end else begin
         perr_d = perr_q;
      end
      if (overrun_s) begin
         oerr_d = 1'b1;
      end else if (err_clr) begin
         oerr_d = 1'b0;
      end else begin
         oerr_d = oerr_q;
      end
   end

   // Control FSM and registered outputs; reset drops the stream at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= ZERO_IDX;
         data_q  <= {dataWidth{1'b0}};
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         pend_q  <= 1'b0;
         perr_q  <= 1'b0;
         oerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         pend_q  <= pend_d;
         perr_q  <= perr_d;
         oerr_q  <= oerr_d;
      end
   end

   assign ser_data    = data_q;
   assign ser_valid   = valid_q;
   assign ser_idx     = idx_q;
   assign busy        = busy_q;
   assign err_partial = perr_q;
   assign err_overrun = oerr_q;

endmodule
